// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the frame scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    RASTER    = 2'd2,
    WAIT_SWAP = 2'd3
  } frame_sched_state;

  localparam logic [15:0] DEFAULT_CLEAR_COLOR = 16'h0000;

endpackage

// File: rtl/frame_scheduler_if.sv
// Framebuffer write port plus the rasterizer write stream that feeds it.
interface frame_scheduler_if #(
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = 16
);
  logic                 raster_wr_en;
  logic [ADDR_BITS-1:0] raster_wr_addr;
  logic [DATA_BITS-1:0] raster_wr_data;
  logic                 fb_wr_en;
  logic                 fb_wr_bank;
  logic [ADDR_BITS-1:0] fb_wr_addr;
  logic [DATA_BITS-1:0] fb_wr_data;

  modport master (
    input  raster_wr_en, raster_wr_addr, raster_wr_data,
    output fb_wr_en, fb_wr_bank, fb_wr_addr, fb_wr_data
  );

  modport slave (
    output raster_wr_en, raster_wr_addr, raster_wr_data,
    input  fb_wr_en, fb_wr_bank, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/frame_scheduler_clear.sv
// Clear engine: after start, sweeps addresses 0..SIZE-1, one per cycle.
module fb_clear_engine #(
  parameter int ADDR_BITS = 14,
  parameter int SIZE      = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 valid,
  output logic                 last
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (start) begin
      valid <= 1'b1;
      addr  <= '0;
    end else if (valid) begin
      if (addr == LAST_ADDR) begin
        valid <= 1'b0;
        addr  <= '0;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  assign last = valid && (addr == LAST_ADDR);

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame raster sequencer: bank swap on vsync, clear, then rasterize.
// Optional two-bank operation: FRAME_SCHEDULER_DOUBLE_BUFFER_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter logic [FRAMEBUFFER_DATA_BITS-1:0] CLEAR_COLOR = DEFAULT_CLEAR_COLOR,
  parameter int TRI_COUNT_BITS        = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vsync,
  input  logic [TRI_COUNT_BITS-1:0] tri_count,
  output logic                      raster_start,
  input  logic                      raster_done,
  frame_scheduler_if.master         wr,
  output logic                      display_bank,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      overrun
);
  localparam logic [FRAMEBUFFER_ADDR_BITS:0] SIZE_EXT =
    (FRAMEBUFFER_ADDR_BITS + 1)'(FRAMEBUFFER_SIZE);

  frame_sched_state            state, state_d;
  logic [TRI_COUNT_BITS-1:0]   tri_q;
  logic                        clr_start, clr_valid, clr_last;
  logic [FRAMEBUFFER_ADDR_BITS-1:0] clr_addr;
  logic                        swap, raster_start_d, overrun_d, rast_accept;
  logic                        rast_en_q;
  logic [FRAMEBUFFER_ADDR_BITS-1:0] rast_addr_q;
  logic [FRAMEBUFFER_DATA_BITS-1:0] rast_data_q;

  fb_clear_engine #(
    .ADDR_BITS (FRAMEBUFFER_ADDR_BITS),
    .SIZE      (FRAMEBUFFER_SIZE)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .addr  (clr_addr),
    .valid (clr_valid),
    .last  (clr_last)
  );

  always_comb begin
    state_d        = state;
    clr_start      = 1'b0;
    swap           = 1'b0;
    raster_start_d = 1'b0;
    overrun_d      = 1'b0;
    case (state)
      IDLE: begin
        if (vsync) begin
          clr_start = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        overrun_d = vsync;
        if (clr_last) begin
          if (tri_q == '0) begin
            state_d = WAIT_SWAP;
          end else begin
            state_d        = RASTER;
            raster_start_d = 1'b1;
          end
        end
      end
      RASTER: begin
        overrun_d = vsync;
        if (raster_done) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vsync) begin
          swap      = 1'b1;
          clr_start = 1'b1;
          state_d   = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rasterizer writes are only honoured in RASTER and inside the bank.
  assign rast_accept = (state == RASTER) && wr.raster_wr_en &&
                       ({1'b0, wr.raster_wr_addr} < SIZE_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tri_q        <= '0;
      raster_start <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
      rast_en_q    <= 1'b0;
      rast_addr_q  <= '0;
      rast_data_q  <= '0;
    end else begin
      state        <= state_d;
      if (clr_start) tri_q <= tri_count;
      raster_start <= raster_start_d;
      frame_done   <= swap;
      overrun      <= overrun_d;
      busy         <= (state_d == CLEAR) || (state_d == RASTER);
      rast_en_q    <= rast_accept;
      rast_addr_q  <= rast_accept ? wr.raster_wr_addr : '0;
      rast_data_q  <= rast_accept ? wr.raster_wr_data : '0;
    end
  end

`ifdef FRAME_SCHEDULER_DOUBLE_BUFFER_EN
  logic front_q, wr_bank_q;

  // On a swap the old front bank becomes the new back bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q   <= 1'b0;
      wr_bank_q <= 1'b0;
    end else if (swap) begin
      front_q   <= ~front_q;
      wr_bank_q <= front_q;
    end else if (clr_start) begin
      wr_bank_q <= ~front_q;
    end
  end

  assign display_bank  = front_q;
  assign wr.fb_wr_bank = wr_bank_q;
`else
  assign display_bank  = 1'b0;
  assign wr.fb_wr_bank = 1'b0;
`endif

  // Clear and raster streams never overlap, so a simple priority mux suffices.
  assign wr.fb_wr_en   = clr_valid | rast_en_q;
  assign wr.fb_wr_addr = clr_valid ? clr_addr : rast_addr_q;
  assign wr.fb_wr_data = clr_valid ? CLEAR_COLOR : rast_data_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler on a 4x4 display: directed frames plus a per-cycle model check.
module tb_frame_scheduler;
  localparam int SIZE = 16;
  localparam int AW   = 5;
`ifdef FRAME_SCHEDULER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic [8:0] tri_count = '0;
  logic raster_done = 1'b0;
  logic raster_start, display_bank, frame_done, busy, overrun;

  int tests = 0;
  int fails = 0;

  frame_scheduler_if #(.ADDR_BITS(AW), .DATA_BITS(16)) wr ();

  frame_scheduler #(
    .DISPLAY_WIDTH(4), .DISPLAY_HEIGHT(4), .FRAMEBUFFER_ADDR_BITS(AW)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .tri_count(tri_count),
    .raster_start(raster_start), .raster_done(raster_done), .wr(wr),
    .display_bank(display_bank), .frame_done(frame_done), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phases of a frame, bank ownership, expected next-cycle outputs.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RASTER = 2, M_WAIT = 3;
  int ph = M_IDLE;
  int idx = 0;
  int mtri = 0;
  bit front = 0, mbank = 0;
  bit m_en = 0, m_fd = 0, m_rs = 0, m_ov = 0, m_busy = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_data = '0;

  task automatic begin_frame();
    mtri   = int'(tri_count);
    ph     = M_CLEAR;
    idx    = 0;
    mbank  = DB ? !front : 1'b0;
    m_en   = 1;
    m_addr = '0;
    m_data = 16'h0000;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ph = M_IDLE; idx = 0; mtri = 0; front = 0; mbank = 0;
      m_en = 0; m_fd = 0; m_rs = 0; m_ov = 0; m_busy = 0; m_addr = '0; m_data = '0;
    end else begin
      m_fd = 0; m_rs = 0; m_ov = 0; m_en = 0; m_addr = '0; m_data = '0;
      case (ph)
        M_IDLE: if (vsync) begin_frame();
        M_CLEAR: begin
          if (vsync) m_ov = 1;
          if (idx == SIZE - 1) begin
            if (mtri == 0) ph = M_WAIT;
            else begin ph = M_RASTER; m_rs = 1; end
          end else begin
            idx++;
            m_en = 1; m_addr = AW'(idx); m_data = 16'h0000;
          end
        end
        M_RASTER: begin
          if (vsync) m_ov = 1;
          if (wr.raster_wr_en && int'(wr.raster_wr_addr) < SIZE) begin
            m_en = 1; m_addr = wr.raster_wr_addr; m_data = wr.raster_wr_data;
          end
          if (raster_done) ph = M_WAIT;
        end
        default: begin
          if (vsync) begin
            if (DB) front = !front;
            m_fd = 1;
            begin_frame();
          end
        end
      endcase
      m_busy = (ph == M_CLEAR) || (ph == M_RASTER);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_fb_wr_en",    32'(wr.fb_wr_en),   32'(m_en));
      chk("m_fb_wr_addr",  32'(wr.fb_wr_addr), 32'(m_addr));
      chk("m_fb_wr_data",  32'(wr.fb_wr_data), 32'(m_data));
      chk("m_fb_wr_bank",  32'(wr.fb_wr_bank), 32'(mbank));
      chk("m_display_bank",32'(display_bank),  32'(front));
      chk("m_frame_done",  32'(frame_done),    32'(m_fd));
      chk("m_raster_start",32'(raster_start),  32'(m_rs));
      chk("m_busy",        32'(busy),          32'(m_busy));
      chk("m_overrun",     32'(overrun),       32'(m_ov));
    end
  end

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(wr.fb_wr_en),   32'd0);
    chk({tag, "_addr"},  32'(wr.fb_wr_addr), 32'd0);
    chk({tag, "_data"},  32'(wr.fb_wr_data), 32'd0);
    chk({tag, "_bank"},  32'(wr.fb_wr_bank), 32'd0);
    chk({tag, "_disp"},  32'(display_bank),  32'd0);
    chk({tag, "_fd"},    32'(frame_done),    32'd0);
    chk({tag, "_rs"},    32'(raster_start),  32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_ovr"},   32'(overrun),       32'd0);
  endtask

  initial begin
    wr.raster_wr_en = 1'b0; wr.raster_wr_addr = '0; wr.raster_wr_data = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: first frame clear into bank 1 (or 0 single-bank), stray raster inputs ignored
    tri_count = 9'd2;
    pulse_vsync();
    for (int i = 0; i < SIZE; i++) begin
      chk("t1_en",   32'(wr.fb_wr_en),   32'd1);
      chk("t1_addr", 32'(wr.fb_wr_addr), 32'(i));
      chk("t1_data", 32'(wr.fb_wr_data), 32'h0000);
      chk("t1_bank", 32'(wr.fb_wr_bank), DB ? 32'd1 : 32'd0);
      chk("t1_disp", 32'(display_bank),  32'd0);
      if (i == 3) begin
        wr.raster_wr_en = 1'b1; wr.raster_wr_addr = 5'd2; wr.raster_wr_data = 16'hFFFF;
        raster_done = 1'b1;
      end
      if (i == 4) begin wr.raster_wr_en = 1'b0; raster_done = 1'b0; end
      @(negedge clk);
    end
    chk("t1_raster_start", 32'(raster_start), 32'd1);
    chk("t1_busy",         32'(busy),         32'd1);

    // 2: in-range raster write forwarded one cycle later, out-of-range dropped
    wr.raster_wr_en = 1'b1; wr.raster_wr_addr = 5'd5; wr.raster_wr_data = 16'hF800;
    @(negedge clk);
    chk("t2_en",   32'(wr.fb_wr_en),   32'd1);
    chk("t2_addr", 32'(wr.fb_wr_addr), 32'd5);
    chk("t2_data", 32'(wr.fb_wr_data), 32'hF800);
    chk("t2_bank", 32'(wr.fb_wr_bank), DB ? 32'd1 : 32'd0);
    wr.raster_wr_addr = 5'd20;
    @(negedge clk);
    chk("t2_drop", 32'(wr.fb_wr_en), 32'd0);
    wr.raster_wr_en = 1'b0;

    // 3: raster_done then vsync swaps banks
    raster_done = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    pulse_vsync();
    chk("t3_fd",   32'(frame_done),    32'd1);
    chk("t3_disp", 32'(display_bank),  DB ? 32'd1 : 32'd0);
    chk("t3_bank", 32'(wr.fb_wr_bank), 32'd0);
    chk("t3_addr", 32'(wr.fb_wr_addr), 32'd0);
    chk("t3_en",   32'(wr.fb_wr_en),   32'd1);
    @(negedge clk);
    chk("t3_fd_off", 32'(frame_done), 32'd0);

    // 4: vsync while clearing address 7 -> overrun, clear continues, no swap
    repeat (6) @(negedge clk);
    chk("t4_addr7", 32'(wr.fb_wr_addr), 32'd7);
    pulse_vsync();
    chk("t4_ovr",   32'(overrun),       32'd1);
    chk("t4_addr8", 32'(wr.fb_wr_addr), 32'd8);
    chk("t4_no_fd", 32'(frame_done),    32'd0);
    chk("t4_disp",  32'(display_bank),  DB ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("t4_ovr_off", 32'(overrun), 32'd0);
    repeat (6) @(negedge clk);
    chk("t4_addr15", 32'(wr.fb_wr_addr), 32'd15);
    tri_count = 9'd0;
    @(negedge clk);
    chk("t4_rs", 32'(raster_start), 32'd1);
    raster_done = 1'b1;
    @(negedge clk);
    raster_done = 1'b0;
    pulse_vsync();
    chk("t4_fd",   32'(frame_done),   32'd1);
    chk("t4_disp2",32'(display_bank), 32'd0);

    // 5: zero triangles -> clear only, then wait for the next swap
    tri_count = 9'd3;
    repeat (15) @(negedge clk);
    chk("t5_addr15", 32'(wr.fb_wr_addr), 32'd15);
    @(negedge clk);
    chk("t5_no_rs", 32'(raster_start), 32'd0);
    chk("t5_busy",  32'(busy),         32'd0);
    chk("t5_en",    32'(wr.fb_wr_en),  32'd0);
    @(negedge clk);
    pulse_vsync();
    chk("t5_fd",   32'(frame_done),   32'd1);
    chk("t5_disp", 32'(display_bank), DB ? 32'd1 : 32'd0);

    // 6: asynchronous reset in the middle of RASTER
    repeat (16) @(negedge clk);
    chk("t6_rs", 32'(raster_start), 32'd1);
    wr.raster_wr_en = 1'b1; wr.raster_wr_addr = 5'd3; wr.raster_wr_data = 16'h1234;
    @(negedge clk);
    chk("t6_wr", 32'(wr.fb_wr_data), 32'h1234);
    wr.raster_wr_addr = 5'd4;
    #3 rst = 1'b1;
    #1 chk_all_zero("t6_async");
    wr.raster_wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_idle");
    pulse_vsync();
    chk("t6_en",   32'(wr.fb_wr_en),   32'd1);
    chk("t6_addr", 32'(wr.fb_wr_addr), 32'd0);
    chk("t6_bank", 32'(wr.fb_wr_bank), DB ? 32'd1 : 32'd0);
    chk("t6_disp", 32'(display_bank),  32'd0);
    chk("t6_fd",   32'(frame_done),    32'd0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
